// File: rtl/lsu_access_ctrl.sv
// Load/store access controller between the core memory stage and a byte-array data memory.
// Latency from accept edge: aligned/byte access 2 cycles, split access 1+N cycles, illegal/trapped 1 cycle.
// Backpressure: req_ready is high only in IDLE; a request presented at any other time is ignored and must be held.
//
// Ports:
//   clk, rst_n                     clock (posedge), asynchronous active-low reset
//   req_valid/req_ready            request handshake, taken on req_valid & req_ready at posedge
//   is_load, is_store, funct3      request kind and RV32I width/sign code
//   addr, wdata                    byte address and store data
//   resp_valid, rdata, err         one-cycle response; rdata is extended load data (0 for stores)
//   mem_read, mem_write            encoded operation to the data memory (0 when idle)
//   mem_addr, mem_wdata, mem_rdata memory address/write data; mem_rdata is a combinational read
module lsu_access_ctrl #(
  parameter int ADDR_W        = 12,
  parameter bit MISALIGN_TRAP = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              is_load,
  input  logic              is_store,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              resp_valid,
  output logic [31:0]       rdata,
  output logic              err,
  output logic [2:0]        mem_read,
  output logic [1:0]        mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_BYTES  = 2'd2,
    S_RESP   = 2'd3
  } state_e;

  state_e state_q, state_d;

  // Captured request and data buffers
  logic              ld_q, ld_d;
  logic              st_q, st_d;
  logic [2:0]        f3_q, f3_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       buf_q, buf_d;    // raw load data, extended only when presented
  logic              err_q, err_d;
  logic [1:0]        cnt_q, cnt_d;    // byte index within a split access

  // Request decode (only meaningful while IDLE)
  logic req_take;
  logic req_illegal;
  logic req_half;
  logic req_word;
  logic req_misal;
  logic req_trap;

  // Split-access bookkeeping
  logic [1:0] cnt_last;
  logic       bytes_done;

  // RV32I load funct3 -> memory read encoding
  function automatic logic [2:0] load_enc(input logic [2:0] f3);
    case (f3)
      3'b000:  load_enc = 3'b101;  // LB
      3'b001:  load_enc = 3'b110;  // LH
      3'b010:  load_enc = 3'b111;  // LW
      3'b100:  load_enc = 3'b001;  // LBU
      3'b101:  load_enc = 3'b010;  // LHU
      default: load_enc = 3'b000;
    endcase
  endfunction

  // RV32I store funct3 -> memory write encoding
  function automatic logic [1:0] store_enc(input logic [2:0] f3);
    case (f3)
      3'b000:  store_enc = 2'b01;  // SB
      3'b001:  store_enc = 2'b10;  // SH
      3'b010:  store_enc = 2'b11;  // SW
      default: store_enc = 2'b00;
    endcase
  endfunction

  // Sign/zero extension of little-endian raw data. Applied uniformly so that
  // split accesses (assembled from bytes) and single accesses share one path;
  // re-extending data the memory already extended is harmless.
  function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [31:0] raw);
    case (f3)
      3'b000:  load_ext = {{24{raw[7]}}, raw[7:0]};
      3'b001:  load_ext = {{16{raw[15]}}, raw[15:0]};
      3'b100:  load_ext = {24'h0, raw[7:0]};
      3'b101:  load_ext = {16'h0, raw[15:0]};
      default: load_ext = raw;
    endcase
  endfunction

  always_comb begin
    req_take  = req_valid && (state_q == S_IDLE);
    req_half  = (funct3[1:0] == 2'b01);
    req_word  = (funct3[1:0] == 2'b10);
    req_misal = (req_half && addr[0]) || (req_word && (addr[1:0] != 2'b00));

    req_illegal = (is_load == is_store);
    if (is_load && !(funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})) begin
      req_illegal = 1'b1;
    end
    if (is_store && !(funct3 inside {3'b000, 3'b001, 3'b010})) begin
      req_illegal = 1'b1;
    end

    req_trap = req_illegal || (MISALIGN_TRAP && req_misal);
  end

  // Split accesses are 2 bytes for halfwords, 4 for words
  always_comb begin
    cnt_last   = (f3_q[1:0] == 2'b10) ? 2'd3 : 2'd1;
    bytes_done = (cnt_q == cnt_last);
  end

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (req_take) begin
          if (req_trap) begin
            state_d = S_RESP;
          end else if (req_misal) begin
            state_d = S_BYTES;
          end else begin
            state_d = S_ACCESS;
          end
        end
      end
      S_ACCESS: state_d = S_RESP;
      S_BYTES: begin
        if (bytes_done) begin
          state_d = S_RESP;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Request capture and data buffers
  // ---------------------------------------------------------------------
  always_comb begin
    ld_d    = ld_q;
    st_d    = st_q;
    f3_d    = f3_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    buf_d   = buf_q;
    err_d   = err_q;
    cnt_d   = cnt_q;

    if (req_take) begin
      ld_d    = is_load;
      st_d    = is_store;
      f3_d    = funct3;
      addr_d  = addr;
      wdata_d = wdata;
      buf_d   = '0;
      err_d   = req_trap;
      cnt_d   = '0;
    end else if (state_q == S_ACCESS) begin
      if (ld_q) begin
        buf_d = mem_rdata;
      end
    end else if (state_q == S_BYTES) begin
      cnt_d = cnt_q + 2'd1;
      if (ld_q) begin
        buf_d[8*cnt_q +: 8] = mem_rdata[7:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ld_q    <= 1'b0;
      st_q    <= 1'b0;
      f3_q    <= 3'b000;
      addr_q  <= '0;
      wdata_q <= '0;
      buf_q   <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      ld_q    <= ld_d;
      st_q    <= st_d;
      f3_q    <= f3_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      buf_q   <= buf_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  // ---------------------------------------------------------------------
  // FSM: outputs. Every output is a function of registered state only, so
  // an asynchronous reset returns all of them to idle values at once.
  // ---------------------------------------------------------------------
  always_comb begin
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    rdata      = 32'h0;
    err        = 1'b0;
    mem_read   = 3'b000;
    mem_write  = 2'b00;
    mem_addr   = '0;
    mem_wdata  = 32'h0;

    case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
      end
      S_ACCESS: begin
        mem_addr = addr_q;
        if (ld_q) begin
          mem_read = load_enc(f3_q);
        end else if (st_q) begin
          mem_write = store_enc(f3_q);
          mem_wdata = wdata_q;
        end
      end
      S_BYTES: begin
        // Address wraps naturally at ADDR_W bits
        mem_addr = addr_q + {{(ADDR_W-2){1'b0}}, cnt_q};
        if (ld_q) begin
          mem_read = 3'b001;
        end else begin
          mem_write = 2'b01;
          mem_wdata = {24'h0, wdata_q[8*cnt_q +: 8]};
        end
      end
      S_RESP: begin
        resp_valid = 1'b1;
        err        = err_q;
        if (ld_q && !err_q) begin
          rdata = load_ext(f3_q, buf_q);
        end
      end
      default: begin
        req_ready = 1'b0;
      end
    endcase
  end

endmodule
